exu_mc: RTL and testbench
=========================

// Module: exu_mc
// PURPOSE
//   Multi-cycle, handshaked execute stage: the successor to the single-cycle EXU.
//   Holds the integer register file, ALU, result select and an iterative multiplier.
//   Sits between the IDU (valid/ready in) and the LSU/WBU (valid/ready out).
//   One instruction in flight; register write-back on the output handshake.
// PARAMETERS
//   XLEN      32  datapath width
//   NREG      32  register count; AW = $clog2(NREG)
//   MUL_STEP  1   multiplier bits retired per cycle; XLEN % MUL_STEP == 0
// PORTS
//   clk            in   1     clock
//   rst_n          in   1     synchronous reset, active low
//   in_valid       in   1     decoded instruction valid
//   in_ready       out  1     stage can accept (state==IDLE)
//   in_rs1/in_rs2  in   AW    source register indices
//   in_rd          in   AW    destination register index
//   in_reg_write   in   1     write rd at retirement
//   in_imm         in   XLEN  extended immediate
//   in_alu_src     in   1     SrcB: 0=rf[rs2], 1=imm
//   in_alu_op      in   5     ALU op, encoding below
//   in_res_sel     in   3     result: 0 ALU,1 ld_data,2 PC+4,3 PC target,4 imm; others->0
//   in_pc_plus4    in   XLEN  PC+4 of instruction
//   in_pc_target   in   XLEN  branch/jump target
//   out_valid      out  1     result valid, held until taken
//   out_ready      in   1     downstream accepts
//   out_alu_result out  XLEN  ALU result (also memory address)
//   out_store_data out  XLEN  rf[rs2] captured at accept
//   out_zero       out  1     out_alu_result == 0
//   out_result     out  XLEN  selected write-back value
//   ld_data        in   XLEN  load data, valid in cycle of out handshake
//   busy           out  1     state != IDLE
//   dbg_a0         out  XLEN  rf[10], combinational (0 if NREG<=10)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state IDLE, out_valid=0, all out_* regs 0, rf all 0.
//     Reset mid-MUL or mid-DONE aborts the instruction; no write-back.
//   FSM: IDLE -> accept (in_valid&in_ready) -> DONE (non-mul) | MUL (op 10/11).
//     MUL: XLEN/MUL_STEP cycles of shift-add on latched operands, then DONE.
//     DONE: out_valid=1; out_* stable; on out_valid&out_ready -> IDLE.
//   At accept: latch SrcA=rf[rs1], SrcB per in_alu_src, store_data=rf[rs2],
//     rd, reg_write, res_sel, imm, pc_plus4, pc_target. Other cycles ignore in_*.
//   Latency: ALU op out_valid the cycle after accept; mul after 1+XLEN/MUL_STEP.
//   Throughput: next accept earliest the cycle after output handshake.
//   ALU ops: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLT(signed) 6 SLTU 7 SLL 8 SRL 9 SRA
//     10 MUL (low XLEN of product) 11 MULHU (high XLEN, unsigned); others -> 0.
//     Shift amount = SrcB[$clog2(XLEN)-1:0]; add/sub wrap modulo 2^XLEN.
//   out_result for res_sel=1 is ld_data combinationally; all others registered.
//   Write-back: on out handshake, if reg_write && rd!=0, rf[rd] <= out_result.
//     rf[0] reads 0 always; writes to rd=0 dropped.
//   No hazard logic: write-back completes before next accept reads rf.
//   out_ready while !out_valid ignored; in_valid outside IDLE not accepted.
// TESTING
//   Reset then read: dbg_a0=0, out_valid=0, in_ready=1, busy=0.
//   ADDI x10=x0+5 (alu_src=1, imm=5, op 0, res 0), out_ready=1 -> out_valid
//     1 cycle after accept, out_result=5, dbg_a0=5 next cycle.
//   SUB x1=x10-x10 -> out_alu_result=0, out_zero=1; SRA of 0x80000000 by 4 ->
//     0xF8000000; SLT -1<1 ->1, SLTU 0xFFFFFFFF<1 ->0.
//   MUL 0xFFFFFFFF*0xFFFFFFFF: op10 -> 0x00000001, op11 -> 0xFFFFFFFE;
//     out_valid exactly 33 cycles after accept (MUL_STEP=1), in_ready=0 throughout.
//   Backpressure: out_ready=0 for 5 cycles -> outputs stable, in_ready=0, no rf
//     write; rd=0 write with imm=7 -> rf[0] still reads 0.
//   Reset asserted mid-MUL -> IDLE next cycle, out_valid=0, target rd unchanged.

Source files
------------

// File: rtl/exu_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : exu_mc_if
// Description : Handshake bundle between IDU, execute stage and LSU/WBU.
// Revision    : 1.0 - initial release
// ============================================================================
interface exu_mc_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic [AW-1:0]   in_rd;
    logic            in_reg_write;
    logic [XLEN-1:0] in_imm;
    logic            in_alu_src;
    logic [4:0]      in_alu_op;
    logic [2:0]      in_res_sel;
    logic [XLEN-1:0] in_pc_plus4;
    logic [XLEN-1:0] in_pc_target;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_alu_result;
    logic [XLEN-1:0] out_store_data;
    logic            out_zero;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] ld_data;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_reg_write, in_imm, in_alu_src,
               in_alu_op, in_res_sel, in_pc_plus4, in_pc_target, out_ready, ld_data,
        output in_ready, out_valid, out_alu_result, out_store_data, out_zero, out_result
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_reg_write, in_imm, in_alu_src,
               in_alu_op, in_res_sel, in_pc_plus4, in_pc_target, out_ready, ld_data,
        input  in_ready, out_valid, out_alu_result, out_store_data, out_zero, out_result
    );
endinterface
`default_nettype wire

// File: rtl/exu_mc.sv
`default_nettype none
// ============================================================================
// Module      : exu_mc
// Description : Multi-cycle handshaked execute stage (RF, ALU, iterative MUL).
// Revision    : 1.0 - initial release
// ============================================================================
module exu_mc #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    exu_mc_if.slave         bus,
    output logic            busy,
    output logic [XLEN-1:0] dbg_a0
);
    localparam int AW    = $clog2(NREG);
    localparam int SW    = $clog2(XLEN);
    localparam int NSTEP = XLEN / MUL_STEP;
    localparam int CW    = $clog2(NSTEP + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   rf_q [NREG];
    logic [XLEN-1:0]   rf_d [NREG];
    logic [XLEN-1:0]   alu_q, alu_d, store_q, store_d, imm_q, imm_d;
    logic [XLEN-1:0]   pc4_q, pc4_d, tgt_q, tgt_d, mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic              rw_q, rw_d, mulhi_q, mulhi_d;
    logic [2:0]        sel_q, sel_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [XLEN-1:0]   src_a, src_b, rs2_val, alu_val, result;
    logic [SW-1:0]     shamt;
    logic [2*XLEN-1:0] mul_p;
    logic [XLEN:0]     mul_hi;

    always_comb begin
        src_a   = rf_q[bus.in_rs1];
        rs2_val = rf_q[bus.in_rs2];
        src_b   = bus.in_alu_src ? bus.in_imm : rs2_val;
        shamt   = src_b[SW-1:0];
        case (bus.in_alu_op)
            5'd0:    alu_val = src_a + src_b;
            5'd1:    alu_val = src_a - src_b;
            5'd2:    alu_val = src_a & src_b;
            5'd3:    alu_val = src_a | src_b;
            5'd4:    alu_val = src_a ^ src_b;
            5'd5:    alu_val = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            5'd6:    alu_val = {{(XLEN-1){1'b0}}, src_a < src_b};
            5'd7:    alu_val = src_a << shamt;
            5'd8:    alu_val = src_a >> shamt;
            5'd9:    alu_val = $unsigned($signed(src_a) >>> shamt);
            default: alu_val = '0;
        endcase
    end

    // Shift-add: upper half accumulates the multiplicand, lower half holds the multiplier.
    always_comb begin
        mul_p  = prod_q;
        mul_hi = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            mul_hi = {1'b0, mul_p[2*XLEN-1:XLEN]} + (mul_p[0] ? {1'b0, mcand_q} : '0);
            mul_p  = {mul_hi, mul_p[XLEN-1:1]};
        end
    end

    always_comb begin
        case (sel_q)
            3'd0:    result = alu_q;
            3'd1:    result = bus.ld_data;
            3'd2:    result = pc4_q;
            3'd3:    result = tgt_q;
            3'd4:    result = imm_q;
            default: result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rf_d    = rf_q;
        alu_d   = alu_q;
        store_d = store_q;
        imm_d   = imm_q;
        pc4_d   = pc4_q;
        tgt_d   = tgt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        mulhi_d = mulhi_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    store_d = rs2_val;
                    imm_d   = bus.in_imm;
                    pc4_d   = bus.in_pc_plus4;
                    tgt_d   = bus.in_pc_target;
                    rd_d    = bus.in_rd;
                    rw_d    = bus.in_reg_write;
                    sel_d   = bus.in_res_sel;
                    if (bus.in_alu_op == 5'd10 || bus.in_alu_op == 5'd11) begin
                        state_d = S_MUL;
                        mcand_d = src_a;
                        prod_d  = {{XLEN{1'b0}}, src_b};
                        mulhi_d = (bus.in_alu_op == 5'd11);
                        cnt_d   = CW'(NSTEP);
                    end else begin
                        state_d = S_DONE;
                        alu_d   = alu_val;
                    end
                end
            end
            S_MUL: begin
                prod_d = mul_p;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    alu_d   = mulhi_q ? mul_p[2*XLEN-1:XLEN] : mul_p[XLEN-1:0];
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    if (rw_q && rd_q != '0) rf_d[rd_q] = result;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            alu_q   <= '0;
            store_q <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            tgt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            mulhi_q <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rf_q    <= rf_d;
            alu_q   <= alu_d;
            store_q <= store_d;
            imm_q   <= imm_d;
            pc4_q   <= pc4_d;
            tgt_q   <= tgt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            mulhi_q <= mulhi_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready       = (state_q == S_IDLE);
    assign busy               = (state_q != S_IDLE);
    assign bus.out_valid      = (state_q == S_DONE);
    assign bus.out_alu_result = alu_q;
    assign bus.out_store_data = store_q;
    assign bus.out_zero       = (alu_q == '0);
    assign bus.out_result     = result;

    generate
        if (NREG > 10) begin : g_a0
            assign dbg_a0 = rf_q[10];
        end else begin : g_no_a0
            assign dbg_a0 = '0;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_exu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_exu_mc
// Description : Directed self-checking bench for exu_mc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [31:0] dbg_a0;
    int          errors = 0;
    int          checks = 0;

    exu_mc_if #(.XLEN(32), .AW(5)) bus ();

    exu_mc #(.XLEN(32), .NREG(32), .MUL_STEP(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .busy   (busy),
        .dbg_a0 (dbg_a0)
    );

    always #5 clk = ~clk;

    task automatic setup(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic [31:0] imm, input logic src,
                         input logic [4:0] op, input logic [2:0] sel);
        bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_reg_write = rw;
        bus.in_imm = imm; bus.in_alu_src = src; bus.in_alu_op = op; bus.in_res_sel = sel;
    endtask

    task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic [31:0] imm, input logic src,
                        input logic [4:0] op, input logic [2:0] sel);
        setup(rs1, rs2, rd, rw, imm, src, op, sel);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (dbg_a0 !== 32'd0) begin errors++; $display("FAIL reset_a0 got %h exp 0", dbg_a0); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_addi();
        send(5'd0, 5'd0, 5'd10, 1'b1, 32'd5, 1'b1, 5'd0, 3'd0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_result !== 32'd5) begin errors++; $display("FAIL addi_result got %h exp 5", bus.out_result); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL addi_in_ready got %b exp 0", bus.in_ready); end
        retire();
        checks++; if (dbg_a0 !== 32'd5) begin errors++; $display("FAIL addi_a0 got %h exp 5", dbg_a0); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL addi_idle got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_alu();
        send(5'd10, 5'd10, 5'd1, 1'b1, 32'd0, 1'b0, 5'd1, 3'd0);
        checks++; if (bus.out_alu_result !== 32'd0) begin errors++; $display("FAIL sub_result got %h exp 0", bus.out_alu_result); end
        checks++; if (bus.out_zero !== 1'b1) begin errors++; $display("FAIL sub_zero got %b exp 1", bus.out_zero); end
        retire();
        send(5'd0, 5'd0, 5'd2, 1'b1, 32'h8000_0000, 1'b1, 5'd0, 3'd4);
        retire();
        send(5'd0, 5'd0, 5'd3, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd0, 3'd4);
        retire();
        send(5'd2, 5'd10, 5'd0, 1'b0, 32'd4, 1'b1, 5'd9, 3'd0);
        checks++; if (bus.out_alu_result !== 32'hF800_0000) begin errors++; $display("FAIL sra got %h exp f8000000", bus.out_alu_result); end
        checks++; if (bus.out_zero !== 1'b0) begin errors++; $display("FAIL sra_zero got %b exp 0", bus.out_zero); end
        checks++; if (bus.out_store_data !== 32'd5) begin errors++; $display("FAIL store_data got %h exp 5", bus.out_store_data); end
        retire();
        send(5'd3, 5'd0, 5'd0, 1'b0, 32'd1, 1'b1, 5'd5, 3'd0);
        checks++; if (bus.out_alu_result !== 32'd1) begin errors++; $display("FAIL slt got %h exp 1", bus.out_alu_result); end
        retire();
        send(5'd3, 5'd0, 5'd0, 1'b0, 32'd1, 1'b1, 5'd6, 3'd0);
        checks++; if (bus.out_alu_result !== 32'd0) begin errors++; $display("FAIL sltu got %h exp 0", bus.out_alu_result); end
        retire();
        bus.in_pc_plus4 = 32'h0000_0104;
        send(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd0, 3'd2);
        bus.in_pc_plus4 = 32'd0;
        checks++; if (bus.out_result !== 32'h0000_0104) begin errors++; $display("FAIL pc4 got %h exp 104", bus.out_result); end
        retire();
        send(5'd0, 5'd0, 5'd6, 1'b1, 32'd0, 1'b1, 5'd0, 3'd1);
        bus.ld_data = 32'h1234_5678;
        #1;
        checks++; if (bus.out_result !== 32'h1234_5678) begin errors++; $display("FAIL ld_pass got %h exp 12345678", bus.out_result); end
        retire();
        bus.ld_data = 32'd0;
        send(5'd6, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd0, 3'd0);
        checks++; if (bus.out_alu_result !== 32'h1234_5678) begin errors++; $display("FAIL ld_wb got %h exp 12345678", bus.out_alu_result); end
        retire();
    endtask

    task automatic test_mul();
        int cyc;
        int bad;
        for (int k = 0; k < 2; k++) begin
            send(5'd3, 5'd3, 5'd4, (k == 0), 32'd0, 1'b0, (k == 0) ? 5'd10 : 5'd11, 3'd0);
            cyc = 1; bad = 0;
            while (bus.out_valid !== 1'b1 && cyc < 60) begin
                if (bus.in_ready !== 1'b0) bad++;
                @(posedge clk); #1;
                cyc++;
            end
            checks++; if (cyc != 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", cyc); end
            checks++; if (bad != 0) begin errors++; $display("FAIL mul_in_ready got %0d cycles high exp 0", bad); end
            checks++;
            if (k == 0 && bus.out_result !== 32'h0000_0001) begin errors++; $display("FAIL mul_lo got %h exp 1", bus.out_result); end
            else if (k == 1 && bus.out_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got %h exp fffffffe", bus.out_result); end
            retire();
        end
        send(5'd4, 5'd0, 5'd0, 1'b0, 32'd0, 1'b1, 5'd0, 3'd0);
        checks++; if (bus.out_alu_result !== 32'd1) begin errors++; $display("FAIL mul_wb got %h exp 1", bus.out_alu_result); end
        retire();
    endtask

    task automatic test_backpressure();
        send(5'd0, 5'd0, 5'd10, 1'b1, 32'd9, 1'b1, 5'd0, 3'd0);
        setup(5'd0, 5'd0, 5'd10, 1'b1, 32'd100, 1'b1, 5'd0, 3'd0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd9) begin
                errors++; $display("FAIL bp_hold cyc %0d got valid=%b res=%h exp 1/9", i, bus.out_valid, bus.out_result); end
            checks++; if (bus.in_ready !== 1'b0 || dbg_a0 !== 32'd5) begin
                errors++; $display("FAIL bp_stall cyc %0d got in_ready=%b a0=%h exp 0/5", i, bus.in_ready, dbg_a0); end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        retire();
        checks++; if (dbg_a0 !== 32'd9) begin errors++; $display("FAIL bp_wb got %h exp 9", dbg_a0); end
        send(5'd0, 5'd0, 5'd0, 1'b1, 32'd7, 1'b1, 5'd0, 3'd4);
        retire();
        send(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 3'd0);
        checks++; if (bus.out_alu_result !== 32'd0 || bus.out_store_data !== 32'd0) begin
            errors++; $display("FAIL x0_write got alu=%h st=%h exp 0/0", bus.out_alu_result, bus.out_store_data); end
        retire();
    endtask

    task automatic test_back_to_back();
        send(5'd0, 5'd0, 5'd5, 1'b1, 32'd11, 1'b1, 5'd0, 3'd0);
        setup(5'd5, 5'd0, 5'd7, 1'b1, 32'd1, 1'b1, 5'd0, 3'd0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_gap got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_alu_result !== 32'd12) begin
            errors++; $display("FAIL b2b_second got valid=%b alu=%h exp 1/c", bus.out_valid, bus.out_alu_result); end
        retire();
    endtask

    task automatic test_reset_mid_mul();
        send(5'd3, 5'd3, 5'd10, 1'b1, 32'd0, 1'b0, 5'd10, 3'd0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mul_state got valid=%b rdy=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, busy); end
        repeat (40) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0 || dbg_a0 !== 32'd0) begin
            errors++; $display("FAIL rst_mul_wb got valid=%b a0=%h exp 0/0", bus.out_valid, dbg_a0); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ld_data = 32'd0;
        bus.in_pc_plus4 = 32'd0; bus.in_pc_target = 32'd0;
        setup(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_addi();
        test_alu();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
